// File: rtl/mccoy_pkg.sv
// Shared types and constants for the McCoy core stepper.
// The core pins pack clock, reset and instruction into one 8-bit io_in word.
package mccoy_pkg;
  localparam int IW             = 6;
  localparam int CORE_CLK_BIT   = 7;
  localparam int CORE_RST_BIT   = 6;
  localparam int INSTR_SEQ_CLKS = 6;
  localparam int RST_SEQ_CLKS   = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_HI, S_HI_CAP, S_LO, S_LO_CAP,
    S_RST_SETUP, S_RST_HI, S_RST_LO
  } state_e;

  function automatic logic [7:0] io_word(input logic clk_b, input logic rst_b,
                                         input logic [IW-1:0] ins);
    logic [7:0] w;
    w = {2'b00, ins};
    w[CORE_CLK_BIT] = clk_b;
    w[CORE_RST_BIT] = rst_b;
    return w;
  endfunction
endpackage

// File: rtl/mccoy_instr_fifo.sv
// Small instruction FIFO; pointers wrap naturally because DEPTH is a power of two.
module mccoy_instr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int IW    = 6,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [IW-1:0] push_data,
  input  logic          pop,
  output logic [IW-1:0] pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][IW-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mccoy_stepper.sv
// Steps one McCoy core: each instruction is one slow core clock built from six
// system clocks; PC is sampled in the high phase, x8 in the low phase.
module mccoy_stepper #(
  parameter  int DEPTH = 4,
  parameter  int IW    = mccoy_pkg::IW,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr_data,
  input  logic          core_rst_req,
  output logic [7:0]    core_io_in,
  input  logic [7:0]    core_io_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [IW-1:0] res_pc,
  output logic [IW-1:0] res_x8,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);
  import mccoy_pkg::*;

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d, res_pc_q, res_pc_d, res_x8_q, res_x8_d;
  logic          rst_pend_q, rst_pend_d, res_valid_q, res_valid_d;
  logic [7:0]    io_q, io_d;
  logic          pop, fifo_full, fifo_empty;
  logic [IW-1:0] fifo_head;

  mccoy_instr_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
    .clk(clk), .reset(reset),
    .push(instr_valid), .push_data(instr_data),
    .pop(pop), .pop_data(fifo_head),
    .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );

  assign instr_ready = ~fifo_full;
  assign core_io_in  = io_q;
  assign res_valid   = res_valid_q;
  assign res_pc      = res_pc_q;
  assign res_x8      = res_x8_q;
  assign busy        = (state_q != S_IDLE) | rst_pend_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rst_pend_d  = rst_pend_q;
    res_valid_d = res_valid_q;
    res_pc_d    = res_pc_q;
    res_x8_d    = res_x8_q;
    pop         = 1'b0;
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    // A reset request mid-instruction is remembered and served at the next IDLE
    if (core_rst_req && state_q != S_IDLE) rst_pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rst_pend_q || core_rst_req) begin
          state_d    = S_RST_SETUP;
          rst_pend_d = 1'b0;
        end else if (!fifo_empty && !res_valid_q) begin
          pop     = 1'b1;
          instr_d = fifo_head;
          state_d = S_SETUP;
        end
      end
      S_SETUP:     state_d = S_HI;
      S_HI:        state_d = S_HI_CAP;
      S_HI_CAP: begin
        res_pc_d = core_io_out[IW-1:0];
        state_d  = S_LO;
      end
      S_LO:        state_d = S_LO_CAP;
      S_LO_CAP: begin
        res_x8_d    = core_io_out[IW-1:0];
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_RST_SETUP: state_d = S_RST_HI;
      S_RST_HI:    state_d = S_RST_LO;
      S_RST_LO:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Pins are decoded from the next state so they are registered with it
    case (state_d)
      S_SETUP, S_LO, S_LO_CAP: io_d = io_word(1'b0, 1'b0, instr_d);
      S_HI, S_HI_CAP:          io_d = io_word(1'b1, 1'b0, instr_d);
      S_RST_SETUP, S_RST_LO:   io_d = io_word(1'b0, 1'b1, '0);
      S_RST_HI:                io_d = io_word(1'b1, 1'b1, '0);
      default:                 io_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      rst_pend_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_pc_q    <= '0;
      res_x8_q    <= '0;
      io_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rst_pend_q  <= rst_pend_d;
      res_valid_q <= res_valid_d;
      res_pc_q    <= res_pc_d;
      res_x8_q    <= res_x8_d;
      io_q        <= io_d;
    end
  end
endmodule
